// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory command port between an instruction-fetch
// requester and a data-memory requester (reads and FFT write-out).
//
// One transaction is in flight at a time: IDLE picks a winner and latches its
// address and command, ISSUE presents the command until the port accepts it,
// and WAIT_RD / WAIT_WR wait for the completion strobe or a timeout.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   if_req, if_addr     fetch read request (level) and address
//   dm_req, dm_wr,      data request (level), 1 = write, and address
//   dm_addr
//   flush               cancels the fetch requester only
//   dma_ready           memory port accepts the presented command
//   rd_valid, tx_done   read data on bus / write finished
//   mem_address, op     command to the memory port (00 idle, 01 rd, 10 wr)
//   if_valid, dm_done   one-cycle completion pulses per requester
//   stall               a request is pending and not completing this cycle
//   timeout_err         one-cycle pulse when a wait state gives up
module mem_arbiter #(
  parameter int ADDRW      = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [ADDRW-1:0] if_addr,
  input  logic             dm_req,
  input  logic             dm_wr,
  input  logic [ADDRW-1:0] dm_addr,
  input  logic             flush,
  input  logic             dma_ready,
  input  logic             rd_valid,
  input  logic             tx_done,
  output logic [ADDRW-1:0] mem_address,
  output logic [1:0]       op,
  output logic             if_valid,
  output logic             dm_done,
  output logic             stall,
  output logic             timeout_err
);

  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    WAIT_WR = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             win_fetch_q, win_fetch_d;  // latched winner is fetch
  logic             wr_q, wr_d;                // latched command is a write
  logic [ADDRW-1:0] addr_q, addr_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             flushed_q, flushed_d;      // fetch flushed while waiting for data

  logic fetch_ok;
  logic grant_data;
  logic grant_fetch;
  logic fetch_flush;
  logic issue_live;
  logic tmo_hit;

  always_comb begin
    fetch_ok    = if_req & ~flush;
    // Data has priority unless fetch has already been passed over STARVE_MAX times.
    grant_data  = (state_q == IDLE) & dm_req & ~((starve_q == STARVE_LIM) & fetch_ok);
    grant_fetch = (state_q == IDLE) & fetch_ok & ~grant_data;
    fetch_flush = win_fetch_q & flush;
    tmo_hit     = (tmo_q == TMO_LAST);

    state_d     = state_q;
    win_fetch_d = win_fetch_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    tmo_d       = tmo_q;
    flushed_d   = flushed_q;

    unique case (state_q)
      IDLE: begin
        if (grant_data) begin
          win_fetch_d = 1'b0;
          wr_d        = dm_wr;
          addr_d      = dm_addr;
          state_d     = ISSUE;
        end else if (grant_fetch) begin
          win_fetch_d = 1'b1;
          wr_d        = 1'b0;
          addr_d      = if_addr;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        // A flushed fetch is dropped even if the port accepts it this cycle.
        if (fetch_flush) begin
          state_d = IDLE;
        end else if (dma_ready) begin
          state_d   = wr_q ? WAIT_WR : WAIT_RD;
          tmo_d     = '0;
          flushed_d = 1'b0;
        end
      end
      WAIT_RD: begin
        if (fetch_flush) flushed_d = 1'b1;
        if (rd_valid || tmo_hit) state_d = IDLE;
        else                     tmo_d   = tmo_q + TW'(1);
      end
      WAIT_WR: begin
        if (tx_done || tmo_hit) state_d = IDLE;
        else                    tmo_d   = tmo_q + TW'(1);
      end
      default: state_d = IDLE;
    endcase

    // Starvation count only tracks an uninterrupted fetch wait.
    if (!if_req || grant_fetch)     starve_d = '0;
    else if (grant_data)            starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + SW'(1);
    else                            starve_d = starve_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      win_fetch_q <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      starve_q    <= '0;
      tmo_q       <= '0;
      flushed_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_fetch_q <= win_fetch_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      starve_q    <= starve_d;
      tmo_q       <= tmo_d;
      flushed_q   <= flushed_d;
    end
  end

  // Outputs decode registered state; completion pulses follow the strobe
  // combinationally so the requester sees them with the bus data.
  always_comb begin
    issue_live  = (state_q == ISSUE) & ~fetch_flush;
    op          = issue_live ? (wr_q ? 2'b10 : 2'b01) : 2'b00;
    mem_address = issue_live ? addr_q : '0;
    if_valid    = (state_q == WAIT_RD) & rd_valid & win_fetch_q & ~flushed_q & ~flush;
    dm_done     = ((state_q == WAIT_RD) & rd_valid & ~win_fetch_q) |
                  ((state_q == WAIT_WR) & tx_done);
    timeout_err = (((state_q == WAIT_RD) & ~rd_valid) |
                   ((state_q == WAIT_WR) & ~tx_done)) & tmo_hit;
    stall       = ((if_req & ~flush) & ~if_valid) | (dm_req & ~dm_done);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios followed by randomized
// transactions predicted by a transaction-level arbitration model.
module tb_mem_arbiter;

  localparam int ADDRW  = 32;
  localparam int STARVE = 4;
  localparam int TMO    = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             if_req, dm_req, dm_wr, flush, dma_ready, rd_valid, tx_done;
  logic [ADDRW-1:0] if_addr, dm_addr;
  logic [ADDRW-1:0] mem_address;
  logic [1:0]       op;
  logic             if_valid, dm_done, stall, timeout_err;

  int n_cmp = 0;
  int n_bad = 0;

  mem_arbiter #(.ADDRW(ADDRW), .STARVE_MAX(STARVE), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr),
    .flush(flush), .dma_ready(dma_ready), .rd_valid(rd_valid), .tx_done(tx_done),
    .mem_address(mem_address), .op(op), .if_valid(if_valid), .dm_done(dm_done),
    .stall(stall), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Reference model: fetch wins only when data is absent or fetch has been
  // passed over STARVE consecutive times while continuously requesting.
  function automatic bit model_fetch_wins(bit f, bit d, int consec);
    return f && (!d || consec == STARVE);
  endfunction

  function automatic int model_consec(bit f, bit fetch_won, int consec);
    if (!f || fetch_won) return 0;
    return (consec < STARVE) ? consec + 1 : STARVE;
  endfunction

  bit          got[$];
  bit          expf[10];
  int          consec;
  bit          pend_f, pend_d, dwr, win_f, is_wr;
  logic [31:0] fa, da, exp_addr;
  logic [1:0]  exp_op;
  int          dly, wt;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1; if_req = 0; dm_req = 0; dm_wr = 0; flush = 0;
    dma_ready = 0; rd_valid = 0; tx_done = 0; if_addr = '0; dm_addr = '0;
    repeat (2) @(posedge clk);
    mid();
    chk("rst_op", op, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_dm_done", dm_done, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_stall", stall, 0);
    rst = 0;
    nxt();

    // Single fetch read, accepted immediately, data three cycles later.
    if_req = 1; if_addr = 32'h100; dma_ready = 1;
    mid(); chk("f1_idle_op", op, 0); chk("f1_idle_stall", stall, 1); nxt();
    mid(); chk("f1_issue_op", op, 1); chk("f1_issue_addr", mem_address, 32'h100); nxt();
    mid(); chk("f1_w1_op", op, 0); chk("f1_w1_addr", mem_address, 0); nxt();
    mid(); chk("f1_w2_valid", if_valid, 0); nxt();
    rd_valid = 1;
    mid(); chk("f1_valid", if_valid, 1); chk("f1_dm_done", dm_done, 0); chk("f1_stall", stall, 0); nxt();
    rd_valid = 0; if_req = 0; dma_ready = 0;
    mid(); chk("f1_after_valid", if_valid, 0); chk("f1_after_op", op, 0); nxt();
    $display("txn f1: fetch read 0x100 done");

    // Data write held off by the port for five cycles.
    dm_req = 1; dm_wr = 1; dm_addr = 32'h2000;
    mid(); chk("w1_idle_op", op, 0); nxt();
    for (int i = 0; i < 6; i++) begin
      dma_ready = (i == 5);
      mid();
      chk($sformatf("w1_op%0d", i), op, 2);
      chk($sformatf("w1_addr%0d", i), mem_address, 32'h2000);
      chk($sformatf("w1_stall%0d", i), stall, 1);
      nxt();
    end
    dma_ready = 0; rd_valid = 1;
    mid(); chk("w1_rdv_ignored", dm_done, 0); chk("w1_wait_op", op, 0); nxt();
    rd_valid = 0; tx_done = 1;
    mid(); chk("w1_done", dm_done, 1); chk("w1_if_valid", if_valid, 0); chk("w1_stall", stall, 0); nxt();
    tx_done = 0; dm_req = 0; dm_wr = 0;
    mid(); chk("w1_after_done", dm_done, 0); nxt();
    $display("txn w1: data write 0x2000 done");

    // Both requesters held with instant completions: starvation pattern.
    if_req = 1; if_addr = 32'hF00; dm_req = 1; dm_wr = 0; dm_addr = 32'hD00;
    dma_ready = 1; rd_valid = 1;
    consec = 0;
    for (int k = 0; k < 10; k++) begin
      expf[k] = model_fetch_wins(1'b1, 1'b1, consec);
      consec  = model_consec(1'b1, expf[k], consec);
    end
    for (int c = 0; c < 30; c++) begin
      mid();
      if (if_valid) got.push_back(1'b1);
      if (dm_done)  got.push_back(1'b0);
      nxt();
    end
    if_req = 0; dm_req = 0; rd_valid = 0; dma_ready = 0;
    chk("arb_count", got.size(), 10);
    for (int k = 0; k < 10; k++) begin
      if (k < got.size()) chk($sformatf("arb_grant%0d", k), got[k], expf[k]);
    end
    $display("txn arb: %0d grants observed", got.size());

    // Flush while fetch sits in ISSUE drops the command immediately.
    if_req = 1; if_addr = 32'h500;
    mid(); nxt();
    mid(); chk("fl_issue_op", op, 1); chk("fl_issue_addr", mem_address, 32'h500); nxt();
    flush = 1;
    mid(); chk("fl_drop_op", op, 0); chk("fl_drop_stall", stall, 0); nxt();
    flush = 0; if_req = 0; dm_req = 1; dm_wr = 1; dm_addr = 32'h600;
    mid(); chk("fl_idle_op", op, 0); nxt();
    dma_ready = 1;
    mid(); chk("fl_next_op", op, 2); chk("fl_next_addr", mem_address, 32'h600); nxt();
    dma_ready = 0; tx_done = 1;
    mid(); chk("fl_next_done", dm_done, 1); nxt();
    tx_done = 0; dm_req = 0; dm_wr = 0;
    $display("txn flush_issue: fetch dropped, write 0x600 done");

    // Flush while fetch waits for data suppresses if_valid.
    if_req = 1; if_addr = 32'h300; dma_ready = 1;
    mid(); nxt();
    mid(); chk("fw_issue_op", op, 1); nxt();
    dma_ready = 0; flush = 1;
    mid(); chk("fw_flush_valid", if_valid, 0); chk("fw_flush_stall", stall, 0); nxt();
    flush = 0; if_req = 0;
    mid(); nxt();
    rd_valid = 1;
    mid(); chk("fw_suppressed", if_valid, 0); chk("fw_dm_done", dm_done, 0); nxt();
    rd_valid = 0; dm_req = 1; dm_wr = 0; dm_addr = 32'h44;
    mid(); chk("fw_idle_op", op, 0); nxt();
    dma_ready = 1;
    mid(); chk("fw_next_op", op, 1); chk("fw_next_addr", mem_address, 32'h44); nxt();
    dma_ready = 0; rd_valid = 1;
    mid(); chk("fw_next_done", dm_done, 1); chk("fw_next_ifv", if_valid, 0); nxt();
    rd_valid = 0; dm_req = 0;
    $display("txn flush_wait: fetch suppressed, read 0x44 done");

    // Read that never gets data times out after TMO wait cycles.
    dm_req = 1; dm_wr = 0; dm_addr = 32'h700; dma_ready = 1;
    mid(); nxt();
    mid(); chk("to_issue_op", op, 1); nxt();
    dma_ready = 0;
    for (int k = 1; k <= TMO; k++) begin
      mid();
      chk($sformatf("to_err%0d", k), timeout_err, (k == TMO));
      chk($sformatf("to_done%0d", k), dm_done, 0);
      nxt();
    end
    dm_req = 0; rd_valid = 1;
    mid(); chk("to_late_done", dm_done, 0); chk("to_late_ifv", if_valid, 0);
    chk("to_late_err", timeout_err, 0); chk("to_late_op", op, 0); nxt();
    mid(); chk("to_late_done2", dm_done, 0); nxt();
    rd_valid = 0;
    $display("txn timeout: read 0x700 timed out");

    // Asynchronous reset while a command is presented.
    dm_req = 1; dm_wr = 1; dm_addr = 32'hA00;
    mid(); nxt();
    mid(); chk("ra_issue_op", op, 2);
    rst = 1; dm_req = 0; #1;
    chk("ra_async_op", op, 0); chk("ra_async_addr", mem_address, 0);
    nxt(); rst = 0;

    // Asynchronous reset mid WAIT_WR with tx_done already high.
    dm_req = 1; dm_wr = 1; dm_addr = 32'h900; dma_ready = 1;
    mid(); nxt();
    mid(); chk("rw_issue_op", op, 2); nxt();
    dma_ready = 0; tx_done = 1;
    @(negedge clk);
    rst = 1; dm_req = 0; #1;
    chk("rw_async_done", dm_done, 0); chk("rw_async_op", op, 0);
    nxt(); rst = 0;
    mid(); chk("rw_late_done1", dm_done, 0); nxt();
    mid(); chk("rw_late_done2", dm_done, 0); nxt();
    tx_done = 0; dm_wr = 0;
    $display("txn reset: outstanding write abandoned");

    // Randomized transactions against the arbitration model.
    consec = 0; pend_f = 0; pend_d = 0; fa = '0; da = '0; dwr = 0;
    for (int r = 0; r < 40; r++) begin
      if (!pend_f && $urandom_range(0, 1) == 1) begin pend_f = 1; fa = $urandom; end
      if (!pend_d && $urandom_range(0, 2) != 0) begin pend_d = 1; da = $urandom; dwr = $urandom_range(0, 1); end
      if (!pend_f && !pend_d) begin pend_d = 1; da = $urandom; dwr = $urandom_range(0, 1); end
      if_req = pend_f; if_addr = fa; dm_req = pend_d; dm_addr = da; dm_wr = dwr;
      dma_ready = 0; rd_valid = 0; tx_done = 0;
      win_f    = model_fetch_wins(pend_f, pend_d, consec);
      consec   = model_consec(pend_f, win_f, consec);
      is_wr    = !win_f && dwr;
      exp_op   = is_wr ? 2'b10 : 2'b01;
      exp_addr = win_f ? fa : da;

      mid(); chk("rnd_idle_op", op, 0); chk("rnd_idle_stall", stall, pend_f | pend_d); nxt();
      dly = $urandom_range(0, 3);
      for (int i = 0; i <= dly; i++) begin
        dma_ready = (i == dly);
        rd_valid  = $urandom_range(0, 1);
        tx_done   = $urandom_range(0, 1);
        mid();
        chk("rnd_op", op, exp_op);
        chk("rnd_addr", mem_address, exp_addr);
        chk("rnd_issue_pulse", {if_valid, dm_done}, 0);
        nxt();
      end
      dma_ready = 0;
      wt = $urandom_range(0, 3);
      for (int i = 0; i < wt; i++) begin
        rd_valid = is_wr ? 1'($urandom_range(0, 1)) : 1'b0;
        tx_done  = is_wr ? 1'b0 : 1'($urandom_range(0, 1));
        mid();
        chk("rnd_wait_op", op, 0);
        chk("rnd_wait_pulse", {if_valid, dm_done, timeout_err}, 0);
        chk("rnd_wait_stall", stall, pend_f | pend_d);
        nxt();
      end
      rd_valid = !is_wr; tx_done = is_wr;
      mid();
      chk("rnd_if_valid", if_valid, win_f);
      chk("rnd_dm_done", dm_done, !win_f);
      chk("rnd_done_stall", stall, (pend_f && !win_f) || (pend_d && win_f));
      nxt();
      rd_valid = 0; tx_done = 0;
      $display("txn %0d: %s %s addr=%h ready_wait=%0d resp_wait=%0d",
               r, win_f ? "fetch" : "data", is_wr ? "wr" : "rd", exp_addr, dly, wt);
      if (win_f) pend_f = 0; else pend_d = 0;
    end
    if_req = 0; dm_req = 0;
    mid(); chk("end_stall", stall, 0); nxt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
